// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning the HI/LO registers, with a fixed-latency busy window.
// Optional madd/maddu support is enabled by defining E_MDU_MADD_EN.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOP_in,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    output logic        busy,
    output logic [31:0] HILO_out,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef E_MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [3:0]  cnt;

    logic [63:0] mult_s;
    logic [63:0] mult_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [63:0] result;
    logic [3:0]  n_cycles;
    logic        is_compute;

    // Signed division works on magnitudes so -2^31 / -1 wraps to 0x80000000 without relying on
    // the simulator's handling of overflow; a zero divisor keeps the current HI/LO as the result.
    always_comb begin
        mult_s     = {{32{A_in[31]}}, A_in} * {{32{B_in[31]}}, B_in};
        mult_u     = {32'd0, A_in} * {32'd0, B_in};
        abs_a      = A_in[31] ? (~A_in + 32'd1) : A_in;
        abs_b      = B_in[31] ? (~B_in + 32'd1) : B_in;
        q_mag      = (B_in == 32'd0) ? 32'd0 : abs_a / abs_b;
        r_mag      = (B_in == 32'd0) ? 32'd0 : abs_a % abs_b;
        q_u        = (B_in == 32'd0) ? 32'd0 : A_in / B_in;
        r_u        = (B_in == 32'd0) ? 32'd0 : A_in % B_in;
        result     = {hi_q, lo_q};
        n_cycles   = MULT_N;
        is_compute = 1'b0;
        case (MDUOP_in)
            OP_MULT: begin
                result     = mult_s;
                is_compute = 1'b1;
            end
            OP_MULTU: begin
                result     = mult_u;
                is_compute = 1'b1;
            end
            OP_DIV: begin
                if (B_in != 32'd0) begin
                    result[31:0]  = (A_in[31] ^ B_in[31]) ? (~q_mag + 32'd1) : q_mag;
                    result[63:32] = A_in[31] ? (~r_mag + 32'd1) : r_mag;
                end
                n_cycles   = DIV_N;
                is_compute = 1'b1;
            end
            OP_DIVU: begin
                if (B_in != 32'd0) begin
                    result = {r_u, q_u};
                end
                n_cycles   = DIV_N;
                is_compute = 1'b1;
            end
`ifdef E_MDU_MADD_EN
            OP_MADD: begin
                result     = {hi_q, lo_q} + mult_s;
                is_compute = 1'b1;
            end
            OP_MADDU: begin
                result     = {hi_q, lo_q} + mult_u;
                is_compute = 1'b1;
            end
`endif
            default: begin
                is_compute = 1'b0;
            end
        endcase
    end

    // Result is captured at the start edge and only committed to HI/LO when the count expires,
    // so HI/LO and busy change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            cnt     <= 4'd0;
            busy    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                if (is_compute) begin
                    pend_hi <= result[63:32];
                    pend_lo <= result[31:0];
                    cnt     <= n_cycles;
                    busy    <= 1'b1;
                    state   <= RUN;
                end else if (MDUOP_in == OP_MTHI) begin
                    hi_q <= A_in;
                end else if (MDUOP_in == OP_MTLO) begin
                    lo_q <= A_in;
                end
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi_q  <= pend_hi;
                lo_q  <= pend_lo;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    always_comb begin
        HILO_out = 32'd0;
        if (start && MDUOP_in == OP_MFHI) begin
            HILO_out = hi_q;
        end else if (start && MDUOP_in == OP_MFLO) begin
            HILO_out = lo_q;
        end
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; expected values are hand-computed constants.
// Covers madd when E_MDU_MADD_EN is defined, otherwise checks ops 9/10 are inert.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOP_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        busy;
    logic [31:0] HILO_out;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    int total;
    int bad;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDUOP_in (MDUOP_in),
        .A_in     (A_in),
        .B_in     (B_in),
        .busy     (busy),
        .HILO_out (HILO_out),
        .HI_out   (HI_out),
        .LO_out   (LO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        MDUOP_in = op;
        A_in     = a;
        B_in     = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        MDUOP_in = 4'd0;
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        issue_op(4'd7, 32'hAAAA5555, 32'd0);
        issue_op(4'd8, 32'h5555AAAA, 32'd0);
        issue_op(4'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_pre_busy got=%0b want=1", busy); end
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        total++;
        if (HI_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", HI_out); end
        total++;
        if (LO_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", LO_out); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_post_busy got=%0b want=0", busy); end
        start = 1'b1; MDUOP_in = 4'd5;
        #1;
        total++;
        if (HILO_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_mfhi got=%h want=0", HILO_out); end
        start = 1'b0; MDUOP_in = 4'd0;
    endtask

    task automatic test_mult;
        int cycles;
        issue_op(4'd7, 32'h11111111, 32'd0);
        issue_op(4'd1, 32'hFFFFFFFE, 32'd3);
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mult_busy_start got=%0b want=1", busy); end
        start = 1'b1; MDUOP_in = 4'd5;
        #1;
        total++;
        if (HILO_out !== 32'h11111111) begin bad++; $display("[TB] FAIL mfhi_while_busy got=%h want=11111111", HILO_out); end
        start = 1'b0; MDUOP_in = 4'd0;
        wait_busy(cycles);
        total++;
        if (cycles !== 5) begin bad++; $display("[TB] FAIL mult_cycles got=%0d want=5", cycles); end
        total++;
        if (HI_out !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mult_hi got=%h want=ffffffff", HI_out); end
        total++;
        if (LO_out !== 32'hFFFFFFFA) begin bad++; $display("[TB] FAIL mult_lo got=%h want=fffffffa", LO_out); end
        issue_op(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_busy(cycles);
        total++;
        if (cycles !== 5) begin bad++; $display("[TB] FAIL multu_cycles got=%0d want=5", cycles); end
        total++;
        if (HI_out !== 32'h00000002) begin bad++; $display("[TB] FAIL multu_hi got=%h want=00000002", HI_out); end
        total++;
        if (LO_out !== 32'hFFFFFFFA) begin bad++; $display("[TB] FAIL multu_lo got=%h want=fffffffa", LO_out); end
    endtask

    task automatic test_div;
        int cycles;
        issue_op(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_busy(cycles);
        total++;
        if (cycles !== 10) begin bad++; $display("[TB] FAIL div_cycles got=%0d want=10", cycles); end
        total++;
        if (LO_out !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL div_lo got=%h want=fffffffd", LO_out); end
        total++;
        if (HI_out !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL div_hi got=%h want=ffffffff", HI_out); end
        issue_op(4'd4, 32'd7, 32'd0);
        wait_busy(cycles);
        total++;
        if (cycles !== 10) begin bad++; $display("[TB] FAIL divu0_cycles got=%0d want=10", cycles); end
        total++;
        if (LO_out !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL divu0_lo got=%h want=fffffffd", LO_out); end
        total++;
        if (HI_out !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL divu0_hi got=%h want=ffffffff", HI_out); end
        issue_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(cycles);
        total++;
        if (LO_out !== 32'h80000000) begin bad++; $display("[TB] FAIL divovf_lo got=%h want=80000000", LO_out); end
        total++;
        if (HI_out !== 32'h00000000) begin bad++; $display("[TB] FAIL divovf_hi got=%h want=00000000", HI_out); end
        issue_op(4'd4, 32'd100, 32'd7);
        wait_busy(cycles);
        total++;
        if ({HI_out, LO_out} !== {32'd2, 32'd14}) begin bad++; $display("[TB] FAIL divu_hilo got=%h_%h want=00000002_0000000e", HI_out, LO_out); end
    endtask

    task automatic test_move;
        int cycles;
        issue_op(4'd7, 32'h12345678, 32'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy got=%0b want=0", busy); end
        start = 1'b1; MDUOP_in = 4'd5;
        #1;
        total++;
        if (HILO_out !== 32'h12345678) begin bad++; $display("[TB] FAIL mfhi got=%h want=12345678", HILO_out); end
        start = 1'b0; MDUOP_in = 4'd0;
        issue_op(4'd8, 32'h0BADF00D, 32'd0);
        start = 1'b1; MDUOP_in = 4'd6;
        #1;
        total++;
        if (HILO_out !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL mflo got=%h want=0badf00d", HILO_out); end
        start = 1'b0; MDUOP_in = 4'd0;
        issue_op(4'd1, 32'd2, 32'd3);
        issue_op(4'd8, 32'hDEADBEEF, 32'd0);
        total++;
        if (LO_out !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL mtlo_busy_now got=%h want=0badf00d", LO_out); end
        wait_busy(cycles);
        total++;
        if (LO_out !== 32'd6) begin bad++; $display("[TB] FAIL mtlo_busy_after got=%h want=00000006", LO_out); end
        total++;
        if (HI_out !== 32'd0) begin bad++; $display("[TB] FAIL mult_small_hi got=%h want=0", HI_out); end
    endtask

    task automatic test_back_to_back;
        int cycles;
        issue_op(4'd1, 32'd4, 32'd4);
        start = 1'b1; MDUOP_in = 4'd1; A_in = 32'd5; B_in = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0; MDUOP_in = 4'd0;
        wait_busy(cycles);
        cycles = cycles + 1;
        total++;
        if (cycles !== 5) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d want=5", cycles); end
        total++;
        if (LO_out !== 32'd16) begin bad++; $display("[TB] FAIL b2b_lo got=%h want=00000010", LO_out); end
        total++;
        if (HI_out !== 32'd0) begin bad++; $display("[TB] FAIL b2b_hi got=%h want=0", HI_out); end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        total++;
        if ({busy, LO_out} !== {1'b0, 32'd16}) begin bad++; $display("[TB] FAIL b2b_settle got=%0b_%h want=0_00000010", busy, LO_out); end
    endtask

    task automatic test_madd;
        int cycles;
        issue_op(4'd7, 32'd0, 32'd0);
        issue_op(4'd8, 32'hFFFFFFFF, 32'd0);
        issue_op(4'd9, 32'd1, 32'd1);
`ifdef E_MDU_MADD_EN
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL madd_busy got=%0b want=1", busy); end
        wait_busy(cycles);
        total++;
        if (cycles !== 5) begin bad++; $display("[TB] FAIL madd_cycles got=%0d want=5", cycles); end
        total++;
        if (HI_out !== 32'd1) begin bad++; $display("[TB] FAIL madd_hi got=%h want=00000001", HI_out); end
        total++;
        if (LO_out !== 32'd0) begin bad++; $display("[TB] FAIL madd_lo got=%h want=0", LO_out); end
        issue_op(4'd10, 32'hFFFFFFFF, 32'd2);
        wait_busy(cycles);
        total++;
        if ({HI_out, LO_out} !== {32'd2, 32'hFFFFFFFE}) begin bad++; $display("[TB] FAIL maddu_hilo got=%h_%h want=00000002_fffffffe", HI_out, LO_out); end
`else
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL madd_off_busy got=%0b want=0", busy); end
        issue_op(4'd10, 32'd7, 32'd9);
        issue_op(4'd11, 32'd7, 32'd9);
        issue_op(4'd0, 32'd7, 32'd9);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        cycles = 0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL madd_off_busy_late got=%0b want=0", busy); end
        total++;
        if ({HI_out, LO_out} !== {32'd0, 32'hFFFFFFFF}) begin bad++; $display("[TB] FAIL madd_off_hilo got=%h_%h want=00000000_ffffffff", HI_out, LO_out); end
`endif
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        start    = 1'b0;
        MDUOP_in = 4'd0;
        A_in     = 32'd0;
        B_in     = 32'd0;
        #1;
        total++;
        if ({busy, HI_out, LO_out} !== 65'd0) begin bad++; $display("[TB] FAIL init_reset got=%0b_%h_%h want=0_0_0", busy, HI_out, LO_out); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset;
        test_mult;
        test_div;
        test_move;
        test_back_to_back;
        test_madd;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage. Sits beside the ALU and feeds the E/M pipeline register's HILO input.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and owns the architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Raises busy so the hazard unit can stall D-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  MDUOP_in is valid this cycle (instruction in E, not flushed).
- MDUOP_in  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu; 11-15 none.
- A_in  input  32  forwarded rs value.
- B_in  input  32  forwarded rt value.
- busy  output  1  registered; high while an operation is in flight.
- HILO_out  output  32  combinational: HI if start and op=mfhi, LO if start and op=mflo, else 0.
- HI_out  output  32  current HI register (debug/trace).
- LO_out  output  32  current LO register (debug/trace).

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, cnt=0, pending result=0, state=IDLE. Reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE and RUN.
- IDLE, compute op accepted (start=1, op in {1,2,3,4} or enabled {9,10}):
  - latch the computed 64-bit result into pend_hi/pend_lo;
  - cnt <= N, where N = MULT_CYCLES or DIV_CYCLES;
  - busy <= 1; go to RUN.
- RUN: cnt decrements each edge. On the edge where cnt==1: HI<=pend_hi, LO<=pend_lo, busy<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge.
  - HI/LO hold their new values on the same edge busy falls.
- Compute ops with start=1 while busy=1 are ignored; the hazard unit guarantees this does not happen.
- mthi/mtlo (start=1, busy=0): HI<=A_in or LO<=A_in at the next edge; single-cycle; busy stays 0. Ignored while busy.
- mfhi/mflo: combinational, no state change. While busy, HILO_out returns the old HI/LO; the stall prevents consumption.
- Arithmetic:
  - mult: signed 32x32 -> {HI,LO} 64-bit.
  - multu: unsigned 32x32 -> {HI,LO} 64-bit.
  - div/divu: LO=quotient, HI=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - div -2^31 / -1: LO=0x80000000, HI=0.
  - Divide by zero: the operation still runs N cycles with busy, but HI/LO are left unchanged.
- busy is never combinationally derived from start. The hazard unit stalls on (start & op is MDU) | busy.
- Ops 0 and 11-15, or start=0: no effect.

Optional Feature:
- Macro: E_MDU_MADD_EN.
- Defined:
  - op 9 madd: {HI,LO} <= {HI,LO} + signed(A*B).
  - op 10 maddu: {HI,LO} <= {HI,LO} + unsigned(A*B).
  - Both use MULT_CYCLES latency, 64-bit wrap-around, and the {HI,LO} value sampled at the start edge.
- Not defined: ops 9/10 behave as none; no state change, busy stays 0.

Test Plan:
- Reset low mid-div (cycle 4 of 10) -> busy=0, HI=LO=0 immediately; after release, mfhi returns 0.
- mult A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678 then mfhi the next cycle -> HILO_out=0x12345678; mtlo while busy -> LO unchanged.
- Second mult issued while busy with A=5, B=5 -> ignored; HI/LO reflect only the first op, and busy falls on the original schedule.
- E_MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 cycles. Undefined: same stimulus -> HI/LO unchanged, busy stays 0.
